// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX branch redirects, multi-cycle
// EX holds with a watchdog, plus saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MDIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        use_rs1_ID,
  input  logic        use_rs2_ID,
  input  logic [4:0]  rd_EX,
  input  logic        MemRead_EX,
  input  logic        branch_taken_EX,
  input  logic [31:0] branch_target_EX,
  input  logic        mdiv_start_EX,
  input  logic        mdiv_done,
  output logic        PCWrite,
  output logic        Write_IFID,
  output logic        flush_IF,
  output logic        flush_IDEX,
  output logic        stall_EX,
  output logic        PCSrc_IF,
  output logic [31:0] PCTarget_IF,
  output logic        mdiv_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int unsigned CNT_W = $clog2(MDIV_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDIV_TIMEOUT - 1);

  typedef enum logic {IDLE, MWAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;
  logic             lu;
  logic             mdiv_busy;

  assign lu = MemRead_EX && (rd_EX != 5'd0) &&
              ((use_rs1_ID && (rs1_ID == rd_EX)) || (use_rs2_ID && (rs2_ID == rd_EX)));

  // The front end is held from the cycle a multi-cycle op enters EX until done.
  assign mdiv_busy = ((state_q == MWAIT) && !mdiv_done) ||
                     ((state_q == IDLE) && mdiv_start_EX && !mdiv_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mdiv_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mdiv_timeout <= timeout_d;
    end
  end

  // Next-state and combinational control outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = mdiv_timeout;
    PCWrite     = 1'b1;
    Write_IFID  = 1'b1;
    flush_IF    = 1'b0;
    flush_IDEX  = 1'b0;
    stall_EX    = 1'b0;
    PCSrc_IF    = 1'b0;
    PCTarget_IF = '0;

    case (state_q)
      IDLE: begin
        if (mdiv_start_EX && !mdiv_done) begin
          state_d = MWAIT;
          cnt_d   = '0;
        end
      end
      MWAIT: begin
        if (mdiv_done) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset forces the free-running defaults regardless of inputs.
    if (rst_n) begin
      if (mdiv_busy) begin
        PCWrite    = 1'b0;
        Write_IFID = 1'b0;
        stall_EX   = 1'b1;
      end else if (branch_taken_EX && (state_q == IDLE)) begin
        PCSrc_IF    = 1'b1;
        PCTarget_IF = branch_target_EX;
        flush_IF    = 1'b1;
        flush_IDEX  = 1'b1;
      end else if (lu) begin
        PCWrite    = 1'b0;
        Write_IFID = 1'b0;
        flush_IDEX = 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PCWrite && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (flush_IF && (flush_count != 32'hFFFF_FFFF)) flush_count <= flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (watchdog shortened to 8 cycles).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX;
  logic        use_rs1_ID, use_rs2_ID, MemRead_EX;
  logic        branch_taken_EX;
  logic [31:0] branch_target_EX;
  logic        mdiv_start_EX, mdiv_done;
  logic        PCWrite, Write_IFID, flush_IF, flush_IDEX, stall_EX, PCSrc_IF;
  logic [31:0] PCTarget_IF;
  logic        mdiv_timeout;
  logic [31:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

  hazard_ctrl #(.MDIV_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX),
    .branch_taken_EX(branch_taken_EX), .branch_target_EX(branch_target_EX),
    .mdiv_start_EX(mdiv_start_EX), .mdiv_done(mdiv_done),
    .PCWrite(PCWrite), .Write_IFID(Write_IFID),
    .flush_IF(flush_IF), .flush_IDEX(flush_IDEX), .stall_EX(stall_EX),
    .PCSrc_IF(PCSrc_IF), .PCTarget_IF(PCTarget_IF),
    .mdiv_timeout(mdiv_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
    use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; MemRead_EX = 1'b0;
    branch_taken_EX = 1'b0; branch_target_EX = '0;
    mdiv_start_EX = 1'b0; mdiv_done = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Outputs forced to defaults while reset is held, even with a pending start.
    mdiv_start_EX = 1'b1;
    MemRead_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
    #3;
    chk("rst_pcwrite", 32'(PCWrite), 32'd1);
    chk("rst_write_ifid", 32'(Write_IFID), 32'd1);
    chk("rst_stall_ex", 32'(stall_EX), 32'd0);
    chk("rst_flush_idex", 32'(flush_IDEX), 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_timeout", 32'(mdiv_timeout), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Load-use on rs1: one-cycle stall with bubble
    MemRead_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
    #1;
    chk("lu_pcwrite", 32'(PCWrite), 32'd0);
    chk("lu_write_ifid", 32'(Write_IFID), 32'd0);
    chk("lu_flush_idex", 32'(flush_IDEX), 32'd1);
    chk("lu_flush_if", 32'(flush_IF), 32'd0);
    chk("lu_stall_ex", 32'(stall_EX), 32'd0);
    cyc();
    clear_inputs();
    #1;
    chk("lu_after_pcwrite", 32'(PCWrite), 32'd1);
    chk("lu_stall_cycles", stall_cycles, 32'd1);

    // No hazard when rd_EX is x0 or the source is not used
    MemRead_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; use_rs1_ID = 1'b1;
    #1;
    chk("lu_rd0_pcwrite", 32'(PCWrite), 32'd1);
    chk("lu_rd0_flush_idex", 32'(flush_IDEX), 32'd0);
    rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b0;
    #1;
    chk("lu_nouse_pcwrite", 32'(PCWrite), 32'd1);
    use_rs2_ID = 1'b1; rs2_ID = 5'd5;
    #1;
    chk("lu_rs2_pcwrite", 32'(PCWrite), 32'd0);
    cyc();
    clear_inputs();
    #1;
    chk("lu_rs2_stall_cycles", stall_cycles, 32'd2);

    // Branch taken together with a load-use: branch wins, ID squashed
    MemRead_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
    branch_taken_EX = 1'b1; branch_target_EX = 32'h0000_0100;
    #1;
    chk("br_pcsrc", 32'(PCSrc_IF), 32'd1);
    chk("br_target", PCTarget_IF, 32'h0000_0100);
    chk("br_flush_if", 32'(flush_IF), 32'd1);
    chk("br_flush_idex", 32'(flush_IDEX), 32'd1);
    chk("br_pcwrite", 32'(PCWrite), 32'd1);
    chk("br_write_ifid", 32'(Write_IFID), 32'd1);
    cyc();
    clear_inputs();
    branch_target_EX = 32'hDEAD_BEEF;
    #1;
    chk("br_flush_count", flush_count, 32'd1);
    chk("br_stall_cycles", stall_cycles, 32'd2);
    chk("nobr_target_zero", PCTarget_IF, 32'd0);
    clear_inputs();

    // Multi-cycle op: start at cycle 0, done at cycle 4
    mdiv_start_EX = 1'b1;
    #1;
    chk("md_c0_stall_ex", 32'(stall_EX), 32'd1);
    chk("md_c0_pcwrite", 32'(PCWrite), 32'd0);
    cyc();
    mdiv_start_EX = 1'b0;
    #1;
    chk("md_c1_stall_ex", 32'(stall_EX), 32'd1);
    cyc();
    branch_taken_EX = 1'b1; branch_target_EX = 32'h0000_0200;
    #1;
    chk("md_c2_pcsrc", 32'(PCSrc_IF), 32'd0);
    chk("md_c2_target", PCTarget_IF, 32'd0);
    chk("md_c2_flush_if", 32'(flush_IF), 32'd0);
    chk("md_c2_stall_ex", 32'(stall_EX), 32'd1);
    cyc();
    clear_inputs();
    #1;
    chk("md_c3_stall_ex", 32'(stall_EX), 32'd1);
    cyc();
    mdiv_done = 1'b1;
    #1;
    chk("md_c4_stall_ex", 32'(stall_EX), 32'd0);
    chk("md_c4_pcwrite", 32'(PCWrite), 32'd1);
    cyc();
    clear_inputs();
    #1;
    chk("md_stall_cycles", stall_cycles, 32'd6);
    chk("md_flush_count", flush_count, 32'd1);
    chk("md_timeout", 32'(mdiv_timeout), 32'd0);

    // Zero-latency op and stray done are both ignored
    mdiv_start_EX = 1'b1; mdiv_done = 1'b1;
    #1;
    chk("zl_stall_ex", 32'(stall_EX), 32'd0);
    chk("zl_pcwrite", 32'(PCWrite), 32'd1);
    cyc();
    clear_inputs();
    #1;
    chk("zl_idle_pcwrite", 32'(PCWrite), 32'd1);
    mdiv_done = 1'b1;
    #1;
    chk("done_idle_pcwrite", 32'(PCWrite), 32'd1);
    cyc();
    clear_inputs();
    #1;
    chk("zl_stall_cycles", stall_cycles, 32'd6);

    // Watchdog: start with no done, stall lasts 9 cycles
    mdiv_start_EX = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("wd_stall_%0d", i), 32'(stall_EX), 32'd1);
      if (i == 8) chk("wd_timeout_pre", 32'(mdiv_timeout), 32'd0);
      cyc();
      mdiv_start_EX = 1'b0;
    end
    #1;
    chk("wd_release_stall_ex", 32'(stall_EX), 32'd0);
    chk("wd_release_pcwrite", 32'(PCWrite), 32'd1);
    chk("wd_timeout", 32'(mdiv_timeout), 32'd1);
    chk("wd_stall_cycles", stall_cycles, 32'd15);
    MemRead_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7; use_rs2_ID = 1'b1;
    cyc();
    clear_inputs();
    cyc();
    chk("wd_timeout_sticky", 32'(mdiv_timeout), 32'd1);
    chk("wd_lu_stall_cycles", stall_cycles, 32'd16);

    // Reset in the middle of MWAIT
    mdiv_start_EX = 1'b1;
    cyc();
    mdiv_start_EX = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rmw_pre_stall_ex", 32'(stall_EX), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmw_pcwrite", 32'(PCWrite), 32'd1);
    chk("rmw_stall_ex", 32'(stall_EX), 32'd0);
    chk("rmw_stall_cycles", stall_cycles, 32'd0);
    chk("rmw_flush_count", flush_count, 32'd0);
    chk("rmw_timeout", 32'(mdiv_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    #1;
    chk("rmw_idle_stall_ex", 32'(stall_EX), 32'd0);
    chk("rmw_idle_pcwrite", 32'(PCWrite), 32'd1);
    cyc();
    chk("rmw_idle_stall_cycles", stall_cycles, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
